// File: rtl/mul_sequencer.sv
// Control sequencer for a shift-add multiplier: drives regfile port selects
// and datapath enables from a Moore FSM with registered outputs.
//
// state | meaning
// IDLE  | waiting for start
// CLR   | zero the accumulator R2
// PPGEN | partial product R0 & R1 -> R3, early exit if multiplier is zero
// ADD   | R2 + R3 -> R2
// SHL   | multiplicand R0 << 1
// SHR   | multiplier R1 >> 1, count iteration
// DONE  | product valid on A read bus
module mul_sequencer #(
  parameter int N_ITER = 32,
  parameter int CNT_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             b_zero,
  output logic             done,
  output logic             busy,
  output logic [4:0]       rd_en_a,
  output logic [4:0]       rd_en_b,
  output logic [4:0]       wr_en,
  output logic             clr_en,
  output logic             pp_en,
  output logic             add_en,
  output logic             shift_en,
  output logic             shift_dir,
  output logic [CNT_W-1:0] iter_cnt
);

  localparam logic [4:0] R_NONE = 5'b00000;
  localparam logic [4:0] R0     = 5'b00001;
  localparam logic [4:0] R1     = 5'b00010;
  localparam logic [4:0] R2     = 5'b00100;
  localparam logic [4:0] R3     = 5'b01000;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ITER - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    PPGEN = 3'd2,
    ADD   = 3'd3,
    SHL   = 3'd4,
    SHR   = 3'd5,
    DONE  = 3'd6
  } state_t;

  typedef struct packed {
    logic       done;
    logic       busy;
    logic [4:0] rd_a;
    logic [4:0] rd_b;
    logic [4:0] wr;
    logic       clr;
    logic       pp;
    logic       add;
    logic       shift;
    logic       dir;
  } ctrl_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctrl_q, ctrl_d;

  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      CLR: begin
        c.busy = 1'b1;
        c.clr  = 1'b1;
        c.wr   = R2;
      end
      PPGEN: begin
        c.busy = 1'b1;
        c.pp   = 1'b1;
        c.rd_a = R0;
        c.rd_b = R1;
        c.wr   = R3;
      end
      ADD: begin
        c.busy = 1'b1;
        c.add  = 1'b1;
        c.rd_a = R2;
        c.rd_b = R3;
        c.wr   = R2;
      end
      SHL: begin
        c.busy  = 1'b1;
        c.shift = 1'b1;
        c.dir   = 1'b0;
        c.rd_a  = R0;
        c.wr    = R0;
      end
      SHR: begin
        c.busy  = 1'b1;
        c.shift = 1'b1;
        c.dir   = 1'b1;
        c.rd_a  = R1;
        c.wr    = R1;
      end
      DONE: begin
        c.busy = 1'b1;
        c.done = 1'b1;
        c.rd_a = R2;
        c.wr   = R_NONE;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLR;
          cnt_d   = '0;
        end
      end
      CLR:   state_d = PPGEN;
      PPGEN: state_d = b_zero ? DONE : ADD;
      ADD:   state_d = SHL;
      SHL:   state_d = SHR;
      SHR: begin
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = PPGEN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state so they line up with state_q.
    ctrl_d = decode(state_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign done      = ctrl_q.done;
  assign busy      = ctrl_q.busy;
  assign rd_en_a   = ctrl_q.rd_a;
  assign rd_en_b   = ctrl_q.rd_b;
  assign wr_en     = ctrl_q.wr;
  assign clr_en    = ctrl_q.clr;
  assign pp_en     = ctrl_q.pp;
  assign add_en    = ctrl_q.add;
  assign shift_en  = ctrl_q.shift;
  assign shift_dir = ctrl_q.dir;
  assign iter_cnt  = cnt_q;

endmodule
